// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 keyboard transmitter.
// Contents: scan-code constants, FSM state encoding, frame length, and
// helpers that describe the byte sequence emitted for one key event.
package ps2_pkg;

  localparam logic [7:0]  SC_BREAK   = 8'hF0;  // release prefix
  localparam logic [7:0]  SC_SHIFT   = 8'h12;  // left-shift make code
  localparam int unsigned FRAME_BITS = 11;     // start + 8 data + parity + stop
  localparam logic [2:0]  DATA_LAST  = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_GAP
  } ps2_state_t;

  // Index of the final byte in the sequence for this event kind.
  function automatic logic [1:0] seq_last(input logic shifted, input logic rel);
    logic [1:0] n;
    case ({shifted, rel})
      2'b00:   n = 2'd0;
      2'b01:   n = 2'd1;
      2'b10:   n = 2'd1;
      default: n = 2'd3;
    endcase
    return n;
  endfunction

  // Byte number idx of the sequence for this event kind.
  function automatic logic [7:0] seq_byte(input logic [7:0] code, input logic shifted,
                                          input logic rel, input logic [1:0] idx);
    logic [7:0] b;
    case ({shifted, rel})
      2'b01:   b = (idx == 2'd0) ? SC_BREAK : code;
      2'b10:   b = (idx == 2'd0) ? SC_SHIFT : code;
      2'b11: begin
        case (idx)
          2'd0:    b = SC_BREAK;
          2'd1:    b = code;
          2'd2:    b = SC_BREAK;
          default: b = SC_SHIFT;
        endcase
      end
      default: b = code;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/ps2_ascii2scan.sv
// Combinational ASCII to PS/2 set-2 scan-code lookup.
// Ports:
//   i_ascii   - ASCII character
//   o_code    - make code (lowercase letter code for capitals)
//   o_shifted - character is an uppercase letter
//   o_valid   - character has a mapping
module ps2_ascii2scan (
  input  logic [7:0] i_ascii,
  output logic [7:0] o_code,
  output logic       o_shifted,
  output logic       o_valid
);

  logic       w_upper;
  logic [7:0] w_lower;

  assign w_upper = (i_ascii >= 8'h41) && (i_ascii <= 8'h5A);
  assign w_lower = w_upper ? (i_ascii | 8'h20) : i_ascii;

  always_comb begin
    o_code    = '0;
    o_valid   = 1'b1;
    o_shifted = w_upper;
    case (w_lower)
      8'h30: o_code = 8'h45;
      8'h31: o_code = 8'h16;
      8'h32: o_code = 8'h1E;
      8'h33: o_code = 8'h26;
      8'h34: o_code = 8'h25;
      8'h35: o_code = 8'h2E;
      8'h36: o_code = 8'h36;
      8'h37: o_code = 8'h3D;
      8'h38: o_code = 8'h3E;
      8'h39: o_code = 8'h46;
      8'h61: o_code = 8'h1C;
      8'h62: o_code = 8'h32;
      8'h63: o_code = 8'h21;
      8'h64: o_code = 8'h23;
      8'h65: o_code = 8'h24;
      8'h66: o_code = 8'h2B;
      8'h67: o_code = 8'h34;
      8'h68: o_code = 8'h33;
      8'h69: o_code = 8'h43;
      8'h6A: o_code = 8'h3B;
      8'h6B: o_code = 8'h42;
      8'h6C: o_code = 8'h4B;
      8'h6D: o_code = 8'h3A;
      8'h6E: o_code = 8'h31;
      8'h6F: o_code = 8'h44;
      8'h70: o_code = 8'h4D;
      8'h71: o_code = 8'h15;
      8'h72: o_code = 8'h2D;
      8'h73: o_code = 8'h1B;
      8'h74: o_code = 8'h2C;
      8'h75: o_code = 8'h3C;
      8'h76: o_code = 8'h2A;
      8'h77: o_code = 8'h1D;
      8'h78: o_code = 8'h22;
      8'h79: o_code = 8'h35;
      8'h7A: o_code = 8'h1A;
      default: begin
        o_code    = '0;
        o_valid   = 1'b0;
        o_shifted = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/ps2_key_tx.sv
// PS/2 device-side keyboard transmitter: turns ASCII key events into
// make/break scan-code frames on device-driven ps2_clk/ps2_data.
// Ports:
//   clk, rst          - system clock, synchronous active-high reset
//   key_valid/ready   - event handshake; key_ascii, key_release = payload
//   key_err           - one-cycle pulse after accepting an unmapped character
//   ps2_clk, ps2_data - registered PS/2 lines, idle high
//   busy              - inverse of key_ready
module ps2_key_tx
  import ps2_pkg::*;
#(
  parameter int unsigned CLK_HALF = 8,
  parameter int unsigned GAP_CYC  = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_valid,
  input  logic [7:0] key_ascii,
  input  logic       key_release,
  output logic       key_ready,
  output logic       key_err,
  output logic       ps2_clk,
  output logic       ps2_data,
  output logic       busy
);

  localparam int unsigned BIT_CYC = 2 * CLK_HALF;
  localparam int unsigned CNT_TOP = (BIT_CYC > GAP_CYC) ? BIT_CYC : GAP_CYC;
  localparam int unsigned CW      = $clog2(CNT_TOP);
  localparam logic [CW-1:0] BIT_LAST = CW'(BIT_CYC - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYC - 1);
  localparam logic [CW-1:0] HALF     = CW'(CLK_HALF);

  ps2_state_t    r_state, w_state_n;
  logic [CW-1:0] r_cnt, w_cnt_n;
  logic [2:0]    r_bit, w_bit_n;
  logic [1:0]    r_byte, w_byte_n;
  logic [7:0]    r_code;
  logic          r_shift, r_rel, r_mapped;
  logic          r_ps2_clk, r_ps2_data;
  logic          w_clk_n, w_data_n;
  logic          w_bit_end, w_accept;
  logic [1:0]    w_last;
  logic [7:0]    w_frame_byte;
  logic [7:0]    w_map_code;
  logic          w_map_shifted, w_map_valid;

  ps2_ascii2scan u_map (
    .i_ascii   (key_ascii),
    .o_code    (w_map_code),
    .o_shifted (w_map_shifted),
    .o_valid   (w_map_valid)
  );

  assign w_accept  = (r_state == S_IDLE) && key_valid;
  assign w_bit_end = (r_cnt == BIT_LAST);
  assign w_last    = seq_last(r_shift, r_rel);

  // LOAD is the first cycle of the start bit, so the mapping is decided at
  // acceptance and the counter already runs through LOAD into START.
  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    w_bit_n   = r_bit;
    w_byte_n  = r_byte;
    case (r_state)
      S_IDLE: begin
        if (key_valid) begin
          w_state_n = S_LOAD;
          w_cnt_n   = '0;
          w_bit_n   = '0;
          w_byte_n  = '0;
        end
      end
      S_LOAD: begin
        if (!r_mapped) begin
          w_state_n = S_IDLE;
          w_cnt_n   = '0;
        end else begin
          w_state_n = S_START;
          w_cnt_n   = r_cnt + CW'(1);
        end
      end
      S_START: begin
        if (w_bit_end) begin
          w_state_n = S_DATA;
          w_cnt_n   = '0;
          w_bit_n   = '0;
        end else begin
          w_cnt_n = r_cnt + CW'(1);
        end
      end
      S_DATA: begin
        if (w_bit_end) begin
          w_cnt_n = '0;
          if (r_bit == DATA_LAST) begin
            w_state_n = S_PARITY;
            w_bit_n   = '0;
          end else begin
            w_bit_n = r_bit + 3'd1;
          end
        end else begin
          w_cnt_n = r_cnt + CW'(1);
        end
      end
      S_PARITY: begin
        if (w_bit_end) begin
          w_state_n = S_STOP;
          w_cnt_n   = '0;
        end else begin
          w_cnt_n = r_cnt + CW'(1);
        end
      end
      S_STOP: begin
        if (w_bit_end) begin
          w_state_n = S_GAP;
          w_cnt_n   = '0;
        end else begin
          w_cnt_n = r_cnt + CW'(1);
        end
      end
      S_GAP: begin
        if (r_cnt == GAP_LAST) begin
          w_cnt_n = '0;
          if (r_byte == w_last) begin
            w_state_n = S_IDLE;
            w_byte_n  = '0;
          end else begin
            w_state_n = S_LOAD;
            w_byte_n  = r_byte + 2'd1;
          end
        end else begin
          w_cnt_n = r_cnt + CW'(1);
        end
      end
      default: begin
        w_state_n = S_IDLE;
        w_cnt_n   = '0;
        w_bit_n   = '0;
        w_byte_n  = '0;
      end
    endcase
  end

  // Line values are derived from the next state so the registered outputs
  // line up with the state they belong to.
  assign w_frame_byte = seq_byte(r_code, r_shift, r_rel, w_byte_n);

  always_comb begin
    w_clk_n  = 1'b1;
    w_data_n = 1'b1;
    case (w_state_n)
      S_LOAD: begin
        w_data_n = (r_state == S_IDLE) ? ~w_map_valid : 1'b0;
        w_clk_n  = 1'b1;
      end
      S_START: begin
        w_data_n = 1'b0;
        w_clk_n  = (w_cnt_n < HALF);
      end
      S_DATA: begin
        w_data_n = w_frame_byte[w_bit_n];
        w_clk_n  = (w_cnt_n < HALF);
      end
      S_PARITY: begin
        w_data_n = ~^w_frame_byte;
        w_clk_n  = (w_cnt_n < HALF);
      end
      S_STOP: begin
        w_data_n = 1'b1;
        w_clk_n  = (w_cnt_n < HALF);
      end
      default: begin
        w_data_n = 1'b1;
        w_clk_n  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_bit      <= '0;
      r_byte     <= '0;
      r_code     <= '0;
      r_shift    <= 1'b0;
      r_rel      <= 1'b0;
      r_mapped   <= 1'b0;
      r_ps2_clk  <= 1'b1;
      r_ps2_data <= 1'b1;
    end else begin
      r_state    <= w_state_n;
      r_cnt      <= w_cnt_n;
      r_bit      <= w_bit_n;
      r_byte     <= w_byte_n;
      r_ps2_clk  <= w_clk_n;
      r_ps2_data <= w_data_n;
      if (w_accept) begin
        r_code   <= w_map_code;
        r_shift  <= w_map_shifted;
        r_rel    <= key_release;
        r_mapped <= w_map_valid;
      end
    end
  end

  assign key_ready = (r_state == S_IDLE);
  assign busy      = ~key_ready;
  assign key_err   = (r_state == S_LOAD) && !r_mapped;
  assign ps2_clk   = r_ps2_clk;
  assign ps2_data  = r_ps2_data;

endmodule

// File: tb/tb_ps2_key_tx.sv
module tb_ps2_key_tx;

  localparam int unsigned CH        = 2;
  localparam int unsigned GAP       = 5;
  localparam int          FRAME_CYC = 22 * CH;
  localparam int          BUDGET    = 5000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       key_valid = 1'b0;
  logic [7:0] key_ascii = 8'h00;
  logic       key_release = 1'b0;
  logic       key_ready, key_err, ps2_clk, ps2_data, busy;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  logic [7:0] exp_q[$];
  int         start_q[$];
  int         fall1_q[$];
  int         n_frames = 0;
  int         n_falls = 0;
  int         n_err_cyc = 0;

  logic [7:0] dig_codes[10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
  logic [7:0] let_codes[26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                                8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
                                8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};

  ps2_key_tx #(.CLK_HALF(CH), .GAP_CYC(GAP)) dut (
    .clk         (clk),
    .rst         (rst),
    .key_valid   (key_valid),
    .key_ascii   (key_ascii),
    .key_release (key_release),
    .key_ready   (key_ready),
    .key_err     (key_err),
    .ps2_clk     (ps2_clk),
    .ps2_data    (ps2_data),
    .busy        (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: character table lookup plus the make/break byte rules.
  task automatic model_push(input logic [7:0] a, input logic rel, output bit mapped);
    logic [7:0] code;
    bit         sh;
    int         ai;
    ai     = int'(a);
    mapped = 1'b1;
    sh     = 1'b0;
    code   = 8'h00;
    if (ai >= 48 && ai <= 57)       code = dig_codes[ai - 48];
    else if (ai >= 97 && ai <= 122) code = let_codes[ai - 97];
    else if (ai >= 65 && ai <= 90) begin
      code = let_codes[ai - 65];
      sh   = 1'b1;
    end else mapped = 1'b0;
    if (mapped) begin
      if (rel) exp_q.push_back(8'hF0);
      if (sh && !rel) exp_q.push_back(8'h12);
      exp_q.push_back(code);
      if (sh && rel) begin
        exp_q.push_back(8'hF0);
        exp_q.push_back(8'h12);
      end
    end
  endtask

  // Scoreboard check of one decoded frame against the next expected byte.
  task automatic score(input logic [10:0] f);
    logic [7:0]  e;
    logic [10:0] ef;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL unexpected_frame: got byte %02h, expected no frame", f[8:1]);
    end else begin
      e  = exp_q.pop_front();
      ef = {1'b1, ($countones(e) % 2 == 0), e, 1'b0};
      check("frame_byte", int'(f[8:1]), int'(e));
      check("frame_bits", int'(f), int'(ef));
    end
  endtask

  // Monitor: decodes frames at ps2_clk falling edges.
  logic        prev_clk = 1'b1;
  logic        prev_data = 1'b1;
  int          nbits = 0;
  logic [10:0] fr = '0;

  always @(posedge clk) begin
    #1;
    if (key_err === 1'b1) n_err_cyc++;
    if (rst) begin
      nbits = 0;
    end else begin
      if (ps2_data !== prev_data) check("data_change_clk_high", int'(ps2_clk), 1);
      if (prev_clk && !ps2_clk) begin
        n_falls++;
        if (nbits == 0) fall1_q.push_back(cyc);
        fr[nbits] = ps2_data;
        nbits++;
        if (nbits == 11) begin
          nbits = 0;
          n_frames++;
          score(fr);
        end
      end
      if (nbits == 0 && prev_data && !ps2_data) start_q.push_back(cyc);
    end
    prev_clk  = ps2_clk;
    prev_data = ps2_data;
  end

  // Offer one event at a negedge once ready; returns the acceptance cycle.
  task automatic offer(input logic [7:0] a, input logic rel, input bit hold, output int t);
    int n;
    bit m;
    n = 0;
    @(negedge clk);
    while (!key_ready && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    check("ready_before_offer", int'(key_ready), 1);
    key_valid   = 1'b1;
    key_ascii   = a;
    key_release = rel;
    t           = cyc;
    model_push(a, rel, m);
    if (!hold) begin
      @(negedge clk);
      key_valid = 1'b0;
    end
  endtask

  task automatic wait_idle(input string name, output int rc);
    int n;
    n = 0;
    @(negedge clk);
    while (!key_ready && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    rc = cyc;
    check(name, int'(key_ready), 1);
  endtask

  initial begin
    int t, rc, f0, e0;
    bit m;
    logic [7:0] rch;

    repeat (3) @(negedge clk);
    check("rst_ready", int'(key_ready), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_err", int'(key_err), 0);
    check("rst_clk", int'(ps2_clk), 1);
    check("rst_data", int'(ps2_data), 1);
    rst = 1'b0;

    // Press 'a': single frame, start at T+1, first fall at T+3.
    start_q.delete();
    fall1_q.delete();
    offer(8'h61, 1'b0, 1'b0, t);
    check("a_data_T1", int'(ps2_data), 0);
    check("a_clk_T1", int'(ps2_clk), 1);
    check("a_busy_T1", int'(busy), 1);
    wait_idle("a_idle", rc);
    check("a_frames", start_q.size(), 1);
    if (start_q.size() > 0) check("a_start_cyc", start_q[0], t + 1);
    if (fall1_q.size() > 0) check("a_first_fall", fall1_q[0], t + 1 + int'(CH));
    check("a_ready_cyc", rc, t + 1 + FRAME_CYC + int'(GAP));

    // Release 'A': F0,1C,F0,12 with exact gaps.
    start_q.delete();
    offer(8'h41, 1'b1, 1'b0, t);
    wait_idle("A_idle", rc);
    check("A_frames", start_q.size(), 4);
    if (start_q.size() == 4) begin
      for (int i = 0; i < 3; i++)
        check("A_spacing", start_q[i+1] - start_q[i], FRAME_CYC + int'(GAP));
      check("A_ready_cyc", rc, start_q[3] + FRAME_CYC + int'(GAP));
    end

    // '5' then 'Z' with key_valid held throughout.
    offer(8'h35, 1'b0, 1'b1, t);
    @(negedge clk);
    check("hold_ready_low", int'(key_ready), 0);
    key_ascii = 8'h5A;
    rc = 0;
    while (!key_ready && rc < BUDGET) begin
      @(negedge clk);
      rc++;
    end
    check("hold_second_ready", int'(key_ready), 1);
    model_push(8'h5A, 1'b0, m);
    @(negedge clk);
    key_valid = 1'b0;
    wait_idle("hold_idle", rc);

    // Unmapped '#': one-cycle key_err, no clock activity.
    f0 = n_falls;
    e0 = n_err_cyc;
    offer(8'h23, 1'b0, 1'b0, t);
    check("err_pulse_T1", int'(key_err), 1);
    check("err_ready_T1", int'(key_ready), 0);
    @(negedge clk);
    check("err_clear_T2", int'(key_err), 0);
    check("err_ready_T2", int'(key_ready), 1);
    repeat (4) @(negedge clk);
    check("err_no_falls", n_falls - f0, 0);
    check("err_cycles", n_err_cyc - e0, 1);

    // Reset during data bit 4 of the F0 byte of a 'b' release.
    offer(8'h62, 1'b1, 1'b0, t);
    while (cyc < t + 1 + 5 * 2 * int'(CH) + 1) @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check("mrst_clk", int'(ps2_clk), 1);
    check("mrst_data", int'(ps2_data), 1);
    check("mrst_ready", int'(key_ready), 1);
    check("mrst_busy", int'(busy), 0);
    rst = 1'b0;
    f0 = n_falls;
    repeat (60) @(negedge clk);
    check("mrst_quiet", n_falls - f0, 0);
    offer(8'h62, 1'b0, 1'b0, t);
    wait_idle("mrst_b_idle", rc);

    // key_valid pulsed while busy is ignored.
    f0 = n_frames;
    offer(8'h63, 1'b0, 1'b0, t);
    repeat (10) @(negedge clk);
    check("ign_busy", int'(busy), 1);
    key_valid = 1'b1;
    key_ascii = 8'h64;
    @(negedge clk);
    key_valid = 1'b0;
    wait_idle("ign_idle", rc);
    check("ign_frames", n_frames - f0, 1);

    // Random mapped/unmapped events.
    for (int i = 0; i < 8; i++) begin
      case ($urandom_range(0, 3))
        0:       rch = 8'(48 + $urandom_range(0, 9));
        1:       rch = 8'(97 + $urandom_range(0, 25));
        2:       rch = 8'(65 + $urandom_range(0, 25));
        default: rch = 8'($urandom_range(32, 47));
      endcase
      offer(rch, 1'($urandom_range(0, 1)), 1'b0, t);
      wait_idle("rand_idle", rc);
    end

    repeat (5) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
